// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores that drain to memory in order.
// Loads forward from the youngest pending store whose word address (bits [11:0]) matches.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     write,
  output logic [AW-1:0]            write_addr,
  output logic [DW-1:0]            write_val,
  input  logic [AW-1:0]            lookup_addr,
  output logic                     lookup_hit,
  output logic [DW-1:0]            lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned MW = (AW < 12) ? AW : 12;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign in_ready = !full && !rst;
  assign accept   = in_valid && in_ready;
  assign write    = !empty && drain_en && !rst;

  assign write_addr = empty ? '0 : addr_q[head];
  assign write_val  = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (write)  head <= head + 1'b1;
      case ({accept, write})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((k < 32'(cnt)) && (addr_q[idx][MW-1:0] == lookup_addr[MW-1:0])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign lookup_hit  = hit && !rst;
  assign lookup_data = rst ? '0 : hit_data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected stores are queued at issue time,
// a negedge monitor pops and compares each memory write.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_val;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .write(write), .write_addr(write_addr), .write_val(write_val),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } store_t;

  store_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory write must match the oldest outstanding expected store.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h val 0x%0h, expected no write at %0t",
                 write_addr, write_val, $time);
      end else begin
        store_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(write_addr), 64'(e.addr));
        chk("write_val",  64'(write_val),  64'(e.data));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    store_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b1; lookup_addr = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_lookup_hit", 64'(lookup_hit), 64'd0);
    next_cycle();
    rst = 1'b0; drain_en = 1'b0;
    @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_write_addr", 64'(write_addr), 64'd0);
    chk("reset_write_val", 64'(write_val), 64'd0);
    chk("reset_lookup_data", 64'(lookup_data), 64'd0);
    next_cycle();

    // Fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 32'h10 + 32'(i); in_data = 32'hA + 32'(i);
      push_exp(in_addr, in_data);
      @(negedge clk);
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      next_cycle();
    end
    // Fifth push while full is ignored, with and without a same-cycle drain
    in_addr = 32'h99; in_data = 32'hEE;
    @(negedge clk);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    next_cycle();
    chk("fifth_ignored_count", 64'(count), 64'd4);
    drain_en = 1'b1;
    @(negedge clk);
    chk("full_drain_in_ready", 64'(in_ready), 64'd0);
    chk("full_drain_write", 64'(write), 64'd1);
    next_cycle();
    in_valid = 1'b0;
    chk("after_full_drain_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_write", 64'(write), 64'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("drained_empty", 64'(empty), 64'd1);
    chk("drain_idle_write", 64'(write), 64'd0);
    next_cycle();

    // Streaming across pointer wrap
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_addr = 32'(i); in_data = 32'h100 + 32'(i);
      push_exp(in_addr, in_data);
      next_cycle();
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(count), 64'd1);
    next_cycle();
    chk("stream_done_empty", 64'(empty), 64'd1);
    drain_en = 1'b0;

    // Forwarding: youngest of two aliasing stores wins
    in_valid = 1'b1; in_addr = 32'h1005; in_data = 32'h1;
    push_exp(in_addr, in_data);
    next_cycle();
    in_addr = 32'h2005; in_data = 32'h2;
    push_exp(in_addr, in_data);
    next_cycle();
    in_valid = 1'b0;
    lookup_addr = 32'h005;
    @(negedge clk);
    chk("fwd_hit", 64'(lookup_hit), 64'd1);
    chk("fwd_data", 64'(lookup_data), 64'd2);
    next_cycle();
    lookup_addr = 32'h006;
    @(negedge clk);
    chk("fwd_miss_hit", 64'(lookup_hit), 64'd0);
    chk("fwd_miss_data", 64'(lookup_data), 64'd0);
    next_cycle();
    drain_en = 1'b1;
    next_cycle();
    next_cycle();

    // Same-cycle accept is not visible until the next cycle
    in_valid = 1'b1; in_addr = 32'h20; in_data = 32'h7; lookup_addr = 32'h20;
    push_exp(in_addr, in_data);
    @(negedge clk);
    chk("same_cycle_hit", 64'(lookup_hit), 64'd0);
    chk("same_cycle_write", 64'(write), 64'd0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("next_cycle_hit", 64'(lookup_hit), 64'd1);
    chk("next_cycle_data", 64'(lookup_data), 64'd7);
    chk("next_cycle_write", 64'(write), 64'd1);
    next_cycle();
    drain_en = 1'b0;

    // Reset mid-operation discards pending stores (none queued as expected)
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 32'h300 + 32'(i); in_data = 32'h55 + 32'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    chk("pre_reset_count", 64'(count), 64'd3);
    rst = 1'b1; drain_en = 1'b1; lookup_addr = 32'h301;
    @(negedge clk);
    chk("midrst_write", 64'(write), 64'd0);
    chk("midrst_lookup_hit", 64'(lookup_hit), 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_count", 64'(count), 64'd0);
    chk("postrst_write", 64'(write), 64'd0);
    chk("postrst_lookup_hit", 64'(lookup_hit), 64'd0);
    for (int i = 0; i < 4; i++) next_cycle();
    drain_en = 1'b0;
    next_cycle();

    chk("outstanding_expected", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
